qie_readout_sequencer: RTL

QIE_READOUT_SEQUENCER -- requirements
Module: qie_readout_sequencer

---
 rtl/qie_pkg.sv | 34 +++
 rtl/qie_bx_counter.sv | 41 ++++
 rtl/qie_readout_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/qie_pkg.sv
// Shared types and constants for the QIE readout sequencer: FSM encoding,
// orbit length default and the frame word layout.
package qie_pkg;

    localparam int unsigned BX_PER_ORBIT_DEF = 3564;

    localparam int unsigned BX_W    = 12;
    localparam int unsigned CAP_W   = 2;
    localparam int unsigned MANT_W  = 6;
    localparam int unsigned EXP_W   = 2;
    localparam int unsigned TDC_W   = 6;
    localparam int unsigned FIELD_W = MANT_W + EXP_W + TDC_W;
    localparam int unsigned FRAME_W = CAP_W + FIELD_W;
    localparam int unsigned MISS_W  = 8;

    localparam int unsigned TDC_OFF  = 0;
    localparam int unsigned EXP_OFF  = TDC_OFF + TDC_W;
    localparam int unsigned MANT_OFF = EXP_OFF + EXP_W;
    localparam int unsigned CAP_OFF  = MANT_OFF + MANT_W;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_ORBIT = 2'd1,
        ST_RUN        = 2'd2
    } state_e;

    typedef struct packed {
        logic [CAP_W-1:0]  cap_id;
        logic [MANT_W-1:0] mant;
        logic [EXP_W-1:0]  expo;
        logic [TDC_W-1:0]  tdc;
    } frame_t;

endpackage

// File: rtl/qie_bx_counter.sv
// Bunch-crossing and capacitor-ID counters; any cycle without inc_i loads zero.
module qie_bx_counter
    import qie_pkg::*;
#(
    parameter int unsigned BX_PER_ORBIT = BX_PER_ORBIT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [BX_W-1:0]  bx_count_o,
    output logic [CAP_W-1:0] cap_id_o
);

    localparam logic [BX_W-1:0] BX_LAST = BX_W'(BX_PER_ORBIT - 1);

    logic [BX_W-1:0]  bx_q, bx_d;
    logic [CAP_W-1:0] cap_q, cap_d;

    always_comb begin
        bx_d  = '0;
        cap_d = '0;
        if (inc_i) begin
            bx_d  = (bx_q == BX_LAST) ? '0 : bx_q + BX_W'(1);
            cap_d = cap_q + CAP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bx_q  <= '0;
            cap_q <= '0;
        end else begin
            bx_q  <= bx_d;
            cap_q <= cap_d;
        end
    end

    assign bx_count_o = bx_q;
    assign cap_id_o   = cap_q;

endmodule

// File: rtl/qie_readout_sequencer.sv
// QIE front-end readout sequencer: aligns to the orbit marker, steps the
// capacitor ID per bunch crossing and registers one serializer frame per cycle.
module qie_readout_sequencer
    import qie_pkg::*;
#(
    parameter int unsigned BX_PER_ORBIT = BX_PER_ORBIT_DEF
) (
    input  logic                Qie_Ck,
    input  logic                Qie_Reset,
    input  logic                Enable,
    input  logic                Orbit_Sync,
    input  logic                Adc_Valid,
    input  logic [MANT_W-1:0]   Adc_Mant_Data,
    input  logic [EXP_W-1:0]    Adc_Exp_Data,
    input  logic [TDC_W-1:0]    Tdc_Data,
    input  logic                Test_Mode,
    input  logic [FIELD_W-1:0]  Test_Pattern,
    output logic [CAP_W-1:0]    Cap_Id,
    output logic [FRAME_W-1:0]  Frame_Data,
    output logic                Frame_Valid,
    output logic [BX_W-1:0]     Bx_Count,
    output logic [MISS_W-1:0]   Missing_Cnt,
    output logic                Sync_Err,
    output logic                Running
);

    localparam logic [BX_W-1:0]   BX_LAST  = BX_W'(BX_PER_ORBIT - 1);
    localparam logic [MISS_W-1:0] MISS_MAX = '1;

    state_e              state_q, state_d;
    frame_t              frame_q, frame_d;
    logic                valid_q, valid_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic                err_q, err_d;
    logic                running_q, running_d;
    logic                arm_c, run_stay_c, resync_c, cnt_inc_c;

    // Next state, counter control and frame capture.
    always_comb begin
        state_d    = state_q;
        frame_d    = '0;
        valid_d    = 1'b0;
        miss_d     = miss_q;
        err_d      = err_q;
        arm_c      = 1'b0;
        run_stay_c = 1'b0;
        resync_c   = 1'b0;
        cnt_inc_c  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (Enable) begin
                    state_d = ST_WAIT_ORBIT;
                    arm_c   = 1'b1;
                end
            end
            ST_WAIT_ORBIT: begin
                if (!Enable)         state_d = ST_IDLE;
                else if (Orbit_Sync) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!Enable) state_d = ST_IDLE;
                else         run_stay_c = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // An orbit marker anywhere but the last crossing means we lost alignment.
        resync_c  = run_stay_c && Orbit_Sync && (Bx_Count != BX_LAST);
        cnt_inc_c = run_stay_c && !resync_c;

        if (arm_c) begin
            miss_d = '0;
            err_d  = 1'b0;
        end else if (resync_c) begin
            err_d = 1'b1;
        end

        if (run_stay_c) begin
            frame_d.cap_id = Cap_Id;
            if (Test_Mode) begin
                {frame_d.mant, frame_d.expo, frame_d.tdc} = Test_Pattern;
                valid_d = 1'b1;
            end else if (Adc_Valid) begin
                frame_d.mant = Adc_Mant_Data;
                frame_d.expo = Adc_Exp_Data;
                frame_d.tdc  = Tdc_Data;
                valid_d      = 1'b1;
            end else if (miss_q != MISS_MAX) begin
                miss_d = miss_q + MISS_W'(1);
            end
        end

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge Qie_Ck or negedge Qie_Reset) begin
        if (!Qie_Reset) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            valid_q   <= 1'b0;
            miss_q    <= '0;
            err_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            valid_q   <= valid_d;
            miss_q    <= miss_d;
            err_q     <= err_d;
            running_q <= running_d;
        end
    end

    qie_bx_counter #(
        .BX_PER_ORBIT (BX_PER_ORBIT)
    ) u_bx_counter (
        .clk        (Qie_Ck),
        .rst_n      (Qie_Reset),
        .inc_i      (cnt_inc_c),
        .bx_count_o (Bx_Count),
        .cap_id_o   (Cap_Id)
    );

    assign Frame_Data  = frame_q;
    assign Frame_Valid = valid_q;
    assign Missing_Cnt = miss_q;
    assign Sync_Err    = err_q;
    assign Running     = running_q;

endmodule
